// File: rtl/hour_cnt24_if.sv
// hour_cnt24_if: groups the hour counter's stimulus and display signals.
// The pm signal exists only when HOUR12_MODE_EN is defined.
interface hour_cnt24_if;
  logic       carry_in;
  logic       hour_add;
  logic       hour_minus;
  logic [3:0] cnt24_L;
  logic [3:0] cnt24_H;
  logic       day_carry;
`ifdef HOUR12_MODE_EN
  logic       pm;
`endif

  // Drives the counter: upstream minute stage plus the buttons
  modport master (
    output carry_in, hour_add, hour_minus,
`ifdef HOUR12_MODE_EN
    input  pm,
`endif
    input  cnt24_L, cnt24_H, day_carry
  );

  // The counter itself
  modport slave (
    input  carry_in, hour_add, hour_minus,
`ifdef HOUR12_MODE_EN
    output pm,
`endif
    output cnt24_L, cnt24_H, day_carry
  );
endinterface

// File: rtl/hour_cnt24.sv
// hour_cnt24: hour stage of a clock. Counts 00..23 in BCD, advanced by the
// minute-wrap pulse and by add/minus buttons, with a day-wrap pulse out.
// Optional macro HOUR12_MODE_EN: display 12, 01..11 with a registered pm flag.
// The count is held internally as a binary hour 0..23 in both modes; only the
// display mapping differs, so wrap and day-carry logic is shared.
module hour_cnt24 #(
  parameter int unsigned RST_HOUR = 0
) (
  input logic         clk,
  input logic         clr,
  hour_cnt24_if.slave bus
);

  localparam int unsigned RstClip = (RST_HOUR > 23) ? 0 : RST_HOUR;
`ifdef HOUR12_MODE_EN
  // pm is cleared on reset, so the reset hour is folded into the AM half
  localparam logic [4:0] RstInit = 5'(RstClip % 12);
`else
  localparam logic [4:0] RstInit = 5'(RstClip);
`endif

  // Binary hour 0..23 -> {tens, units} BCD as shown on the outputs
  function automatic logic [7:0] disp_bcd(input logic [4:0] h);
    logic [4:0] d;
`ifdef HOUR12_MODE_EN
    d = (h >= 5'd12) ? h - 5'd12 : h;
    if (d == 5'd0) d = 5'd12;
`else
    d = h;
`endif
    if (d >= 5'd20)      disp_bcd = {4'd2, 4'(d - 5'd20)};
    else if (d >= 5'd10) disp_bcd = {4'd1, 4'(d - 5'd10)};
    else                 disp_bcd = {4'd0, 4'(d)};
  endfunction

  logic       add_q1, add_q2, add_arm_q;
  logic       minus_q1, minus_q2, minus_arm_q;
  logic [4:0] hour_q, hour_d;
  logic [3:0] cnt_h_q, cnt_l_q;
  logic       day_carry_q;
  logic       add_edge, minus_edge;
  logic [5:0] sum;
  logic       step_nz;
  logic       wrap_fwd;
  logic [7:0] bcd_d;
`ifdef HOUR12_MODE_EN
  logic       pm_q;
`endif

  // Button edges, net step modulo 24, and next display value
  always_comb begin
    // The arm flag stops a button held through clr from counting on release of clr
    add_edge   = add_q1 & ~add_q2 & add_arm_q;
    minus_edge = minus_q1 & ~minus_q2 & minus_arm_q;
    // Biased by 24 so a -1 step never goes negative: range 23..49
    sum      = {1'b0, hour_q} + 6'(bus.carry_in) + 6'(add_edge) + 6'd24 - 6'(minus_edge);
    step_nz  = (sum != ({1'b0, hour_q} + 6'd24));
    wrap_fwd = (sum >= 6'd48);
    if (sum >= 6'd48)      hour_d = 5'(sum - 6'd48);
    else if (sum >= 6'd24) hour_d = 5'(sum - 6'd24);
    else                   hour_d = 5'(sum);
    bcd_d = disp_bcd(hour_d);
  end

  // Button history, count and registered outputs; clr overrides any step
  always_ff @(posedge clk) begin
    if (clr) begin
      add_q1      <= 1'b0;
      add_q2      <= 1'b0;
      add_arm_q   <= 1'b0;
      minus_q1    <= 1'b0;
      minus_q2    <= 1'b0;
      minus_arm_q <= 1'b0;
      hour_q      <= RstInit;
      {cnt_h_q, cnt_l_q} <= disp_bcd(RstInit);
      day_carry_q <= 1'b0;
`ifdef HOUR12_MODE_EN
      pm_q        <= 1'b0;
`endif
    end else begin
      add_q1      <= bus.hour_add;
      add_q2      <= add_q1;
      add_arm_q   <= add_arm_q | ~bus.hour_add;
      minus_q1    <= bus.hour_minus;
      minus_q2    <= minus_q1;
      minus_arm_q <= minus_arm_q | ~bus.hour_minus;
      day_carry_q <= bus.carry_in & wrap_fwd;
      if (step_nz) begin
        hour_q             <= hour_d;
        {cnt_h_q, cnt_l_q} <= bcd_d;
`ifdef HOUR12_MODE_EN
        pm_q               <= (hour_d >= 5'd12);
`endif
      end
    end
  end

  assign bus.cnt24_H   = cnt_h_q;
  assign bus.cnt24_L   = cnt_l_q;
  assign bus.day_carry = day_carry_q;
`ifdef HOUR12_MODE_EN
  assign bus.pm        = pm_q;
`endif

endmodule
